// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// the NOP word used by flush consumers and the per-cycle control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_IDLE      = 2'd0,
    PIPE_ST_REDIRECT  = 2'd1,
    PIPE_ST_LOAD_WAIT = 2'd2,
    PIPE_ST_LOAD_DONE = 2'd3
  } pipe_st_e;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic mem_req;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_ctrl_tmo.sv
// Saturating load wait counter. expire_o flags the MEM_TIMEOUT-th cycle of a
// load request (the accepting IDLE cycle counts as the first).
module pipe_ctrl_tmo #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic incr_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] CNT_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0] CNT_MAX   = '1;
  localparam logic [TMO_W-1:0] EXPIRE_AT = TMO_W'(MEM_TIMEOUT - 1);

  // cnt_q holds the number of request cycles already completed.
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_ONE;
    end else if (incr_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: jump redirect, load handshake with timeout, load-use
// bubble. Optional perf counters enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_jump_flag_in,
  input  logic [31:0] ctrl_jump_addr_in,
  input  logic        ctrl_load_req_in,
  input  logic        ctrl_load_use_in,
  input  logic        ctrl_mem_ack_in,
  output logic        ctrl_jump_flag_out,
  output logic [31:0] ctrl_jump_addr_out,
  output logic        ctrl_hold_pc_out,
  output logic        ctrl_hold_if_id_out,
  output logic        ctrl_hold_id_ex_out,
  output logic        ctrl_flush_if_id_out,
  output logic        ctrl_flush_id_ex_out,
  output logic        ctrl_mem_req_out,
  output logic        ctrl_load_done_out,
  output logic        ctrl_load_err_out,
  output logic [31:0] ctrl_stall_cnt_out,
  output logic [31:0] ctrl_flush_cnt_out
);

  pipe_st_e    state_q, state_d;
  logic [31:0] jaddr_q, jaddr_d;
  logic        err_q, err_d;
  logic        tmo_clear, tmo_incr, tmo_expire;
  pipe_ctl_t   ctl, ctl_g;

  pipe_ctrl_tmo #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tmo_clear),
    .incr_i  (tmo_incr),
    .expire_o(tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    jaddr_d   = jaddr_q;
    err_d     = 1'b0;
    tmo_clear = 1'b0;
    tmo_incr  = 1'b0;
    ctl       = '0;
    unique case (state_q)
      PIPE_ST_IDLE: begin
        if (ctrl_jump_flag_in) begin
          ctl.flush_if_id = 1'b1;
          ctl.flush_id_ex = 1'b1;
          jaddr_d         = ctrl_jump_addr_in;
          state_d         = PIPE_ST_REDIRECT;
        end else if (ctrl_load_req_in) begin
          ctl.mem_req    = 1'b1;
          ctl.hold_pc    = 1'b1;
          ctl.hold_if_id = 1'b1;
          ctl.hold_id_ex = 1'b1;
          tmo_clear      = 1'b1;
          state_d        = ctrl_mem_ack_in ? PIPE_ST_LOAD_DONE : PIPE_ST_LOAD_WAIT;
        end else if (ctrl_load_use_in) begin
          ctl.hold_pc     = 1'b1;
          ctl.hold_if_id  = 1'b1;
          ctl.flush_id_ex = 1'b1;
        end
      end
      PIPE_ST_REDIRECT: begin
        // Squash the instruction fetched from the stale PC during the jump cycle.
        ctl.flush_if_id = 1'b1;
        ctl.flush_id_ex = 1'b1;
        state_d         = PIPE_ST_IDLE;
      end
      PIPE_ST_LOAD_WAIT: begin
        ctl.mem_req    = 1'b1;
        ctl.hold_pc    = 1'b1;
        ctl.hold_if_id = 1'b1;
        ctl.hold_id_ex = 1'b1;
        if (ctrl_mem_ack_in) begin
          state_d = PIPE_ST_LOAD_DONE;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = PIPE_ST_IDLE;
        end else begin
          tmo_incr = 1'b1;
        end
      end
      PIPE_ST_LOAD_DONE: begin
        if (ctrl_load_use_in) begin
          ctl.hold_pc     = 1'b1;
          ctl.hold_if_id  = 1'b1;
          ctl.flush_id_ex = 1'b1;
        end
        state_d = PIPE_ST_IDLE;
      end
      default: state_d = PIPE_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_ST_IDLE;
      jaddr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      jaddr_q <= jaddr_d;
      err_q   <= err_d;
    end
  end

  // Reset forces the combinational controls low even while inputs are still active.
  assign ctl_g = rst_n ? ctl : '0;

  assign ctrl_mem_req_out     = ctl_g.mem_req;
  assign ctrl_hold_pc_out     = ctl_g.hold_pc;
  assign ctrl_hold_if_id_out  = ctl_g.hold_if_id & ~ctl_g.flush_if_id;
  assign ctrl_hold_id_ex_out  = ctl_g.hold_id_ex & ~ctl_g.flush_id_ex;
  assign ctrl_flush_if_id_out = ctl_g.flush_if_id;
  assign ctrl_flush_id_ex_out = ctl_g.flush_id_ex;
  assign ctrl_jump_flag_out   = (state_q == PIPE_ST_REDIRECT);
  assign ctrl_jump_addr_out   = ctrl_jump_flag_out ? jaddr_q : 32'h0;
  assign ctrl_load_done_out   = (state_q == PIPE_ST_LOAD_DONE);
  assign ctrl_load_err_out    = err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        jump_acc;

  assign jump_acc = (state_q == PIPE_ST_IDLE) && ctrl_jump_flag_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (ctrl_hold_pc_out) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jump_acc)         flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign ctrl_stall_cnt_out = stall_cnt_q;
  assign ctrl_flush_cnt_out = flush_cnt_q;
`else
  assign ctrl_stall_cnt_out = 32'h0;
  assign ctrl_flush_cnt_out = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned MT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_in = 1'b0;
  logic [31:0] jaddr_in = 32'h0;
  logic        load_req = 1'b0;
  logic        load_use = 1'b0;
  logic        mem_ack = 1'b0;
  logic        jump_out;
  logic [31:0] jaddr_out;
  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
  logic        mem_req, load_done, load_err;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pipe_ctrl #(.MEM_TIMEOUT(MT), .TMO_W(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ctrl_jump_flag_in   (jump_in),
    .ctrl_jump_addr_in   (jaddr_in),
    .ctrl_load_req_in    (load_req),
    .ctrl_load_use_in    (load_use),
    .ctrl_mem_ack_in     (mem_ack),
    .ctrl_jump_flag_out  (jump_out),
    .ctrl_jump_addr_out  (jaddr_out),
    .ctrl_hold_pc_out    (hold_pc),
    .ctrl_hold_if_id_out (hold_if_id),
    .ctrl_hold_id_ex_out (hold_id_ex),
    .ctrl_flush_if_id_out(flush_if_id),
    .ctrl_flush_id_ex_out(flush_id_ex),
    .ctrl_mem_req_out    (mem_req),
    .ctrl_load_done_out  (load_done),
    .ctrl_load_err_out   (load_err),
    .ctrl_stall_cnt_out  (stall_cnt),
    .ctrl_flush_cnt_out  (flush_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: what is pending, in plain flags and counts
  bit          m_redirect;
  logic [31:0] m_target;
  bit          m_in_load;
  int          m_load_cycles;
  bit          m_done_now;
  bit          m_err_now;
  logic [31:0] m_stall, m_flush;
  logic        e_jf, e_hpc, e_hif, e_hex, e_fif, e_fex, e_mr, e_ld, e_le;
  logic [31:0] e_ja;

  always @(negedge clk) begin
    e_jf = 0; e_ja = 0; e_hpc = 0; e_hif = 0; e_hex = 0;
    e_fif = 0; e_fex = 0; e_mr = 0; e_ld = 0; e_le = 0;
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk32("stall_cnt", stall_cnt, m_stall);
    chk32("flush_cnt", flush_cnt, m_flush);
`else
    chk32("stall_cnt", stall_cnt, 32'h0);
    chk32("flush_cnt", flush_cnt, 32'h0);
`endif
    if (!rst_n) begin
      m_redirect = 0; m_target = 0; m_in_load = 0; m_load_cycles = 0;
      m_done_now = 0; m_err_now = 0; m_stall = 0; m_flush = 0;
    end else begin
      e_le = m_err_now;
      m_err_now = 0;
      if (m_redirect) begin
        e_jf = 1; e_ja = m_target; e_fif = 1; e_fex = 1;
        m_redirect = 0;
      end else if (m_in_load) begin
        e_mr = 1; e_hpc = 1; e_hif = 1; e_hex = 1;
        m_load_cycles++;
        if (mem_ack) begin
          m_in_load = 0; m_done_now = 1;
        end else if (m_load_cycles == MT) begin
          m_in_load = 0; m_err_now = 1;
        end
      end else if (m_done_now) begin
        e_ld = 1;
        m_done_now = 0;
        if (load_use) begin e_hpc = 1; e_hif = 1; e_fex = 1; end
      end else if (jump_in) begin
        e_fif = 1; e_fex = 1;
        m_redirect = 1; m_target = jaddr_in; m_flush = m_flush + 1;
      end else if (load_req) begin
        e_mr = 1; e_hpc = 1; e_hif = 1; e_hex = 1;
        m_load_cycles = 1;
        if (mem_ack) m_done_now = 1;
        else         m_in_load  = 1;
      end else if (load_use) begin
        e_hpc = 1; e_hif = 1; e_fex = 1;
      end
      e_hif = e_hif & ~e_fif;
      e_hex = e_hex & ~e_fex;
      if (e_hpc) m_stall = m_stall + 1;
    end
    chk1("jump_flag_out", jump_out, e_jf);
    chk32("jump_addr_out", jaddr_out, e_ja);
    chk1("hold_pc", hold_pc, e_hpc);
    chk1("hold_if_id", hold_if_id, e_hif);
    chk1("hold_id_ex", hold_id_ex, e_hex);
    chk1("flush_if_id", flush_if_id, e_fif);
    chk1("flush_id_ex", flush_id_ex, e_fex);
    chk1("mem_req", mem_req, e_mr);
    chk1("load_done", load_done, e_ld);
    chk1("load_err", load_err, e_le);
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic lr,
                       input logic lu, input logic ack);
    jump_in = j; jaddr_in = a; load_req = lr; load_use = lu; mem_ack = ack;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset mem_req", mem_req, 1'b0);
    chk1("reset jump_flag_out", jump_out, 1'b0);
    chk32("reset jump_addr_out", jaddr_out, 32'h0);
    #2 rst_n = 1'b1;

    // load with ack on the third request cycle
    next_cycle(); drive(0, 0, 1, 0, 0);
    @(negedge clk); chk1("ld c1 mem_req", mem_req, 1); chk1("ld c1 hold_pc", hold_pc, 1);
    next_cycle();
    @(negedge clk); chk1("ld c2 mem_req", mem_req, 1); chk1("ld c2 hold_id_ex", hold_id_ex, 1);
    next_cycle(); drive(0, 0, 1, 0, 1);
    @(negedge clk); chk1("ld c3 mem_req", mem_req, 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("ld c4 load_done", load_done, 1); chk1("ld c4 hold_pc", hold_pc, 0);
    chk1("ld c4 mem_req", mem_req, 0);

    // jump to 0x100
    next_cycle(); drive(1, 32'h0000_0100, 0, 0, 0);
    @(negedge clk); chk1("jmp c1 flush_if_id", flush_if_id, 1); chk1("jmp c1 flag", jump_out, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("jmp c2 flag", jump_out, 1); chk32("jmp c2 addr", jaddr_out, 32'h100);
    chk1("jmp c2 flush_id_ex", flush_id_ex, 1);
    next_cycle();
    @(negedge clk); chk1("jmp c3 flag", jump_out, 0); chk1("jmp c3 flush_if_id", flush_if_id, 0);

    // second jump, then counters
    next_cycle(); drive(1, 32'h0000_0200, 0, 0, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk32("perf stall_cnt", stall_cnt, 32'd3);
    chk32("perf flush_cnt", flush_cnt, 32'd2);
`endif

    // timeout with no ack
    next_cycle(); drive(0, 0, 1, 0, 0);
    for (int i = 1; i <= int'(MT); i++) begin
      @(negedge clk); chk1($sformatf("tmo c%0d mem_req", i), mem_req, 1);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("tmo err", load_err, 1); chk1("tmo mem_req", mem_req, 0);
    chk1("tmo done", load_done, 0);
    next_cycle();
    @(negedge clk); chk1("tmo err end", load_err, 0);

    // load-use bubble
    next_cycle(); drive(0, 0, 0, 1, 0);
    @(negedge clk); chk1("lu hold_pc", hold_pc, 1); chk1("lu hold_if_id", hold_if_id, 1);
    chk1("lu flush_id_ex", flush_id_ex, 1); chk1("lu hold_id_ex", hold_id_ex, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("lu release", hold_pc, 0);

    // jump + load_req + load_use together
    next_cycle(); drive(1, 32'hDEAD_BEE0, 1, 1, 0);
    @(negedge clk); chk1("sim mem_req", mem_req, 0); chk1("sim flush_if_id", flush_if_id, 1);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("sim flag", jump_out, 1); chk32("sim addr", jaddr_out, 32'hDEAD_BEE0);

    // async reset during LOAD_WAIT
    next_cycle(); drive(0, 0, 1, 0, 0);
    next_cycle();
    @(negedge clk); chk1("rst pre mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk1("rst async mem_req", mem_req, 0); chk1("rst async hold_pc", hold_pc, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk); chk1("rst load_done", load_done, 0); chk1("rst load_err", load_err, 0);
    #2 rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      drive($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    repeat (8) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline controller for the 5-bit-regfile RV32 core.
- Sits beside exec and sequences it. It consumes exec's jump request, the decode-stage load-use hazard flag and exec's load request.
- Drives hold/flush for the PC, IF/ID and ID/EX registers, the registered redirect to the PC, and the data-memory load handshake.
- Only block allowed to stall or squash the pipeline.

Parameters:
- MEM_TIMEOUT, 16: max cycles a load waits for ctrl_mem_ack_in before abort (range 2..255).
- TMO_W, 8: width of the load wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_jump_flag_in  in  1  exec branch/jal taken
- ctrl_jump_addr_in  in  32  exec jump target
- ctrl_load_req_in  in  1  exec holds a LOAD (opcode OP_TYPE_LOAD)
- ctrl_load_use_in  in  1  ID instr reads rd of LOAD in exec
- ctrl_mem_ack_in  in  1  data memory read data valid
- ctrl_jump_flag_out  out  1  registered PC redirect
- ctrl_jump_addr_out  out  32  registered redirect target
- ctrl_hold_pc_out  out  1  freeze PC
- ctrl_hold_if_id_out  out  1  freeze IF/ID
- ctrl_hold_id_ex_out  out  1  freeze ID/EX
- ctrl_flush_if_id_out  out  1  squash IF/ID to NOP
- ctrl_flush_id_ex_out  out  1  squash ID/EX to NOP
- ctrl_mem_req_out  out  1  data memory read request
- ctrl_load_done_out  out  1  one-cycle pulse: load data valid for writeback
- ctrl_load_err_out  out  1  one-cycle pulse: load timed out
- ctrl_stall_cnt_out  out  32  stall cycle counter (see Optional Feature)
- ctrl_flush_cnt_out  out  32  flush event counter (see Optional Feature)

Behaviour:
- Clocking and reset:
  - Clock is clk, rising edge. Reset is rst_n, asynchronous, active-low.
  - On reset, every output is 0, the state is IDLE, the jump address register is 32'h0, the wait counter is 0 and the perf counters are 0.
- Reset asserted mid-load drops ctrl_mem_req_out immediately (asynchronously); no done or err pulse is produced.
- FSM states: IDLE, REDIRECT, LOAD_WAIT, LOAD_DONE.
- IDLE, priority jump > load_req > load_use:
  - jump_flag_in=1:
    - Comb: flush_if_id=1 and flush_id_ex=1 this cycle.
    - Register jump_addr_in. Next state REDIRECT.
    - load_req_in and load_use_in are ignored this cycle.
  - load_req_in=1:
    - Comb: mem_req=1; hold_pc, hold_if_id and hold_id_ex all 1.
    - Counter cleared to 1.
    - If mem_ack_in=1 in the same cycle, go to LOAD_DONE; otherwise go to LOAD_WAIT.
  - load_use_in=1 only:
    - Comb: hold_pc=1, hold_if_id=1, flush_id_ex=1 (one bubble). Stay in IDLE.
- REDIRECT:
  - jump_flag_out=1 and jump_addr_out=registered target for exactly one cycle.
  - flush_if_id=1 and flush_id_ex=1 again, squashing the instruction fetched during the jump cycle.
  - All inputs are ignored. Next state IDLE.
  - Jump latency: exec flag to PC redirect is 1 cycle.
- LOAD_WAIT:
  - mem_req=1 and all three holds=1.
  - On mem_ack_in=1, go to LOAD_DONE.
  - Otherwise, if counter==MEM_TIMEOUT:
    - load_err pulses 1 in the next cycle; mem_req deasserts then.
    - Holds release; next state IDLE.
  - Otherwise the counter increments. The counter saturates and never wraps.
- LOAD_DONE:
  - load_done=1 for one cycle; mem_req=0; holds=0. Next state IDLE.
  - If ctrl_load_use_in=1 in this cycle, the one-bubble rule is applied.
- ctrl_jump_flag_in is ignored outside IDLE. Exec only asserts it with a valid instruction, which cannot coexist with held stages.
- hold and flush both asserted on the same register: flush wins (downstream requirement).
- Hold signals never depend on ctrl_mem_ack_in combinationally except through the state, apart from the IDLE same-cycle ack case.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - ctrl_stall_cnt_out increments every cycle hold_pc_out=1.
  - ctrl_flush_cnt_out increments on every cycle with jump_flag_in accepted in IDLE.
  - Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesised.

Decomposition:
- Shared core_defines: state encodings (PIPE_ST_IDLE=2'd0, PIPE_ST_REDIRECT=2'd1, PIPE_ST_LOAD_WAIT=2'd2, PIPE_ST_LOAD_DONE=2'd3) and the NOP encoding 32'h00000013 used by flush consumers.
- One sub-module: pipe_ctrl_tmo, the saturating wait counter with compare-to-MEM_TIMEOUT output.
- Perf counters stay inline.

Test Plan:
- Jump: jump_flag_in=1, addr=32'h0000_0100 for 1 cycle in IDLE -> flushes 1 that cycle and the next; jump_flag_out=1 with addr 32'h100 exactly 1 cycle later; back to IDLE.
- Load with ack on the third wait cycle: load_req=1, ack at cycle 3 -> mem_req high 3 cycles, holds high 3 cycles, load_done pulse at cycle 4, holds 0 at cycle 4.
- Timeout: MEM_TIMEOUT=4, load_req with no ack -> mem_req high 4 cycles, load_err pulse on cycle 5, no load_done, IDLE after.
- Load-use: load_use=1 alone for 1 cycle -> hold_pc=1, hold_if_id=1, flush_id_ex=1 that cycle only; no state change.
- Simultaneous: jump=1, load_req=1, load_use=1 in the same cycle -> jump path only, mem_req stays 0; rst_n low during LOAD_WAIT -> mem_req 0 immediately, all outputs 0.
- Perf, PIPE_CTRL_PERF_CNT_EN defined: the load scenario then 2 jumps -> stall_cnt=3, flush_cnt=2.
